// File: rtl/hiscore_bcd.sv
// High-score tracker with a serial double-dabble binary-to-BCD converter.
// One conversion takes WIDTH shift cycles plus a DONE cycle; the hiscore updates on game_over rising edges.
module hiscore_bcd #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      score,
   input  logic                  game_over,
   input  logic                  start,
   input  logic                  sel_hi,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  digits_valid,
   output logic                  busy,
   output logic [WIDTH-1:0]      hiscore,
   output logic                  new_record
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam longint unsigned DEC_SPAN = 64'd10 ** DIGITS;
   localparam longint unsigned BIN_MAX  = (64'd1 << WIDTH) - 64'd1;

   if (DEC_SPAN <= BIN_MAX) begin : g_digits_too_few
      $error("hiscore_bcd: DIGITS too small to hold the largest WIDTH-bit value");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [WIDTH-1:0]    shreg;
   logic [4*DIGITS-1:0] acc;
   logic [4*DIGITS-1:0] acc_adj;
   logic [4*DIGITS-1:0] acc_step;
   logic [3:0]          nib;
   logic [CW-1:0]       cnt;
   logic                last_step;
   logic                go_q;
   logic                go_rise;

   // One double-dabble step: correct every nibble >= 5, then shift in the operand MSB.
   always_comb begin
      acc_adj = '0;
      nib     = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         nib = acc[4*i +: 4];
         acc_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
      acc_step = {acc_adj[4*DIGITS-2:0], shreg[WIDTH-1]};
   end

   assign last_step = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      busy         = 1'b0;
      digits_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_step) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            digits_valid = 1'b1;
            state_nxt    = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg  <= '0;
         acc    <= '0;
         cnt    <= '0;
         digits <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg <= sel_hi ? hiscore : score;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               acc   <= acc_step;
               shreg <= {shreg[WIDTH-2:0], 1'b0};
               cnt   <= cnt + CW'(1);
               // The final step's result goes straight to digits on the edge entering DONE.
               if (last_step) begin
                  digits <= acc_step;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign go_rise = game_over & ~go_q;

   // go_q clears on reset, so game_over held through reset release counts as a rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         go_q       <= 1'b0;
         hiscore    <= '0;
         new_record <= 1'b0;
      end else begin
         go_q       <= game_over;
         new_record <= 1'b0;
         if (go_rise && (score > hiscore)) begin
            hiscore    <= score;
            new_record <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hiscore_bcd.sv
// Scoreboard bench for hiscore_bcd: stimulus pushes expected digits/hiscore values,
// a monitor pops them whenever digits_valid or new_record is seen.
module tb_hiscore_bcd;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] score;
   logic        game_over;
   logic        start;
   logic        sel_hi;
   logic [19:0] digits;
   logic        digits_valid;
   logic        busy;
   logic [15:0] hiscore;
   logic        new_record;

   int errors = 0;
   int checks = 0;

   logic [19:0] exp_q[$];
   logic [15:0] rec_q[$];

   hiscore_bcd #(.WIDTH(16), .DIGITS(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .score        (score),
      .game_over    (game_over),
      .start        (start),
      .sel_hi       (sel_hi),
      .digits       (digits),
      .digits_valid (digits_valid),
      .busy         (busy),
      .hiscore      (hiscore),
      .new_record   (new_record)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      logic [19:0] e;
      logic [15:0] h;
      forever begin
         @(posedge clk);
         #1;
         if (digits_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: digits=%0h required no pulse", digits);
            end else begin
               e = exp_q.pop_front();
               if (digits !== e) begin
                  errors++;
                  $display("FAIL digits: got %0h required %0h", digits, e);
               end
            end
         end
         if (new_record === 1'b1) begin
            checks++;
            if (rec_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_record: hiscore=%0d required no pulse", hiscore);
            end else begin
               h = rec_q.pop_front();
               if (hiscore !== h) begin
                  errors++;
                  $display("FAIL record_hiscore: got %0d required %0d", hiscore, h);
               end
            end
         end
      end
   end

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL idle_timeout: busy cycles %0d required < 40", n);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      chk({name, "_digits"}, 32'(digits), 32'h0);
      chk({name, "_valid"}, 32'(digits_valid), 32'h0);
      chk({name, "_busy"}, 32'(busy), 32'h0);
      chk({name, "_hiscore"}, 32'(hiscore), 32'h0);
      chk({name, "_record"}, 32'(new_record), 32'h0);
   endtask

   task automatic convert(input logic [15:0] s, input logic [19:0] exp);
      int n;
      @(negedge clk);
      score  = s;
      sel_hi = 1'b0;
      start  = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      start = 1'b0;
      wait_idle(n);
      chk("busy_cycles", 32'(n), 32'd17);
      repeat (2) @(negedge clk);
      chk("digits_hold", 32'(digits), 32'(exp));
   endtask

   initial begin
      int n;
      reset = 1'b1; score = '0; game_over = 1'b0; start = 1'b0; sel_hi = 1'b0;
      #1;
      check_zero_outputs("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      convert(16'd0,     20'h00000);
      convert(16'd1234,  20'h01234);
      convert(16'd65535, 20'h65535);
      convert(16'd9,     20'h00009);

      // Operand captured at start; later score changes are ignored.
      @(negedge clk);
      score = 16'd77; start = 1'b1; exp_q.push_back(20'h00077);
      @(negedge clk);
      start = 1'b0; score = 16'd999;
      wait_idle(n);

      // New record, held game_over, then a lower score.
      @(negedge clk);
      score = 16'd300; game_over = 1'b1; rec_q.push_back(16'd300);
      repeat (10) @(negedge clk);
      game_over = 1'b0;
      repeat (2) @(negedge clk);
      score = 16'd200; game_over = 1'b1;
      repeat (10) @(negedge clk);
      chk("hiscore_kept", 32'(hiscore), 32'd300);
      game_over = 1'b0;

      // Start while busy and in DONE is dropped; start in the next IDLE is taken.
      @(negedge clk);
      score = 16'd4321; start = 1'b1; exp_q.push_back(20'h04321);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!digits_valid && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("done_reached", 32'(n < 40), 32'd1);
      score = 16'd555; start = 1'b1;
      @(negedge clk);
      chk("idle_after_done", 32'(busy), 32'd0);
      exp_q.push_back(20'h00555);
      @(negedge clk);
      start = 1'b0;
      chk("accepted_in_idle", 32'(busy), 32'd1);
      wait_idle(n);

      // Reset with game_over held; release counts as a rise and sets hiscore=100.
      @(negedge clk);
      reset = 1'b1; game_over = 1'b1; score = 16'd100;
      #1;
      check_zero_outputs("reset2");
      @(negedge clk);
      rec_q.push_back(16'd100);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("hiscore_after_release", 32'(hiscore), 32'd100);
      game_over = 1'b0;
      repeat (2) @(negedge clk);

      // Conversion of hiscore on the same edge as a record update uses the old value.
      score = 16'd500; game_over = 1'b1; sel_hi = 1'b1; start = 1'b1;
      exp_q.push_back(20'h00100);
      rec_q.push_back(16'd500);
      @(negedge clk);
      start = 1'b0; sel_hi = 1'b0;
      wait_idle(n);
      chk("hiscore_500", 32'(hiscore), 32'd500);
      game_over = 1'b0;

      // Reset mid-conversion aborts without a pulse.
      @(negedge clk);
      score = 16'd1234; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #1;
      check_zero_outputs("abort");
      @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      convert(16'd42, 20'h00042);

      repeat (3) @(negedge clk);
      chk("pending_digits", 32'(exp_q.size()), 32'd0);
      chk("pending_records", 32'(rec_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
